// File: rtl/day10_min_presses_solver.sv
// Minimum-press solver for one day-10 machine: Gray-code walk over all button subsets.
// Optional DAY10_SOLVER_PRESS_MASK_EN adds a best_mask output with the winning subset.
module day10_min_presses_solver #(
  parameter int MAX_NUM_LIGHTS    = 10,
  parameter int MAX_NUM_BUTTONS   = 13,
  parameter int MAX_NUM_BUTTONS_W = MAX_NUM_BUTTONS <= 1 ? 1 : $clog2(MAX_NUM_BUTTONS + 1),
  parameter int MAX_NUM_LIGHTS_W  = MAX_NUM_LIGHTS <= 1 ? 1 : $clog2(MAX_NUM_LIGHTS + 1)
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [MAX_NUM_LIGHTS_W-1:0]                num_lights,
  input  logic [MAX_NUM_BUTTONS_W-1:0]               num_buttons,
  input  logic [MAX_NUM_BUTTONS*MAX_NUM_LIGHTS-1:0]  buttons,
  input  logic [MAX_NUM_LIGHTS-1:0]                  target_lights_arrangement,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [MAX_NUM_BUTTONS_W-1:0]               min_presses,
  output logic                                       solvable
`ifdef DAY10_SOLVER_PRESS_MASK_EN
  ,
  output logic [MAX_NUM_BUTTONS-1:0]                 best_mask
`endif
);

  localparam int KW = MAX_NUM_BUTTONS + 1;

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t                        state;
  logic [MAX_NUM_LIGHTS-1:0]     btn [MAX_NUM_BUTTONS];
  logic [MAX_NUM_LIGHTS-1:0]     target;
  logic [MAX_NUM_LIGHTS-1:0]     acc;
  logic [MAX_NUM_BUTTONS_W-1:0]  presses;
  logic [MAX_NUM_BUTTONS_W-1:0]  best;
  logic [MAX_NUM_BUTTONS_W-1:0]  n;
  logic [KW-1:0]                 k;
  logic                          found;
`ifdef DAY10_SOLVER_PRESS_MASK_EN
  logic [MAX_NUM_BUTTONS-1:0]    best_gray;
`endif

  logic [MAX_NUM_BUTTONS_W-1:0]  n_clamp;
  logic [MAX_NUM_LIGHTS_W-1:0]   l_clamp;
  logic [MAX_NUM_LIGHTS-1:0]     light_mask;
  logic [MAX_NUM_LIGHTS-1:0]     target_masked;
  logic [MAX_NUM_LIGHTS-1:0]     btn_masked [MAX_NUM_BUTTONS];

  always_comb begin
    n_clamp = (num_buttons > MAX_NUM_BUTTONS_W'(MAX_NUM_BUTTONS)) ?
              MAX_NUM_BUTTONS_W'(MAX_NUM_BUTTONS) : num_buttons;
    l_clamp = (num_lights > MAX_NUM_LIGHTS_W'(MAX_NUM_LIGHTS)) ?
              MAX_NUM_LIGHTS_W'(MAX_NUM_LIGHTS) : num_lights;
    light_mask = '0;
    for (int j = 0; j < MAX_NUM_LIGHTS; j++)
      light_mask[j] = (MAX_NUM_LIGHTS_W'(j) < l_clamp);
    target_masked = target_lights_arrangement & light_mask;
    for (int i = 0; i < MAX_NUM_BUTTONS; i++)
      btn_masked[i] = (MAX_NUM_BUTTONS_W'(i) < n_clamp) ?
                      (buttons[i*MAX_NUM_LIGHTS +: MAX_NUM_LIGHTS] & light_mask) : '0;
  end

  logic [KW-1:0]                 k_low;
  logic [KW-1:0]                 gray;
  logic [MAX_NUM_LIGHTS-1:0]     sel_btn;
  logic [MAX_NUM_LIGHTS-1:0]     acc_next;
  logic                          press_up;
  logic [MAX_NUM_BUTTONS_W-1:0]  presses_next;
  logic                          hit;
  logic                          last;

  // Step k of the Gray walk flips exactly the button at k's lowest set bit.
  always_comb begin
    k_low   = k & (~k + KW'(1));
    gray    = k ^ (k >> 1);
    sel_btn = '0;
    for (int i = 0; i < MAX_NUM_BUTTONS; i++)
      if (k_low[i]) sel_btn = sel_btn | btn[i];
    acc_next     = acc ^ sel_btn;
    press_up     = |(gray & k_low);
    presses_next = press_up ? presses + MAX_NUM_BUTTONS_W'(1) : presses - MAX_NUM_BUTTONS_W'(1);
    hit          = (acc_next == target) && (!found || presses_next < best);
    last         = (k == ((KW'(1) << n) - KW'(1)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      min_presses <= '0;
      solvable    <= 1'b0;
      for (int i = 0; i < MAX_NUM_BUTTONS; i++) btn[i] <= '0;
      target      <= '0;
      acc         <= '0;
      presses     <= '0;
      best        <= '0;
      n           <= '0;
      k           <= '0;
      found       <= 1'b0;
`ifdef DAY10_SOLVER_PRESS_MASK_EN
      best_gray   <= '0;
      best_mask   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            for (int i = 0; i < MAX_NUM_BUTTONS; i++) btn[i] <= btn_masked[i];
            target   <= target_masked;
            acc      <= '0;
            presses  <= '0;
            k        <= KW'(1);
            n        <= n_clamp;
            best     <= '0;
            found    <= (target_masked == '0);
            in_ready <= 1'b0;
`ifdef DAY10_SOLVER_PRESS_MASK_EN
            best_gray <= '0;
`endif
            if (n_clamp != '0) begin
              state <= SEARCH;
            end else begin
              state       <= DONE;
              out_valid   <= 1'b1;
              min_presses <= '0;
              solvable    <= (target_masked == '0);
`ifdef DAY10_SOLVER_PRESS_MASK_EN
              best_mask   <= '0;
`endif
            end
          end
        end
        SEARCH: begin
          acc     <= acc_next;
          presses <= presses_next;
          if (hit) begin
            best  <= presses_next;
            found <= 1'b1;
`ifdef DAY10_SOLVER_PRESS_MASK_EN
            best_gray <= gray[MAX_NUM_BUTTONS-1:0];
`endif
          end
          // The final step's own hit must reach the outputs, so bypass best/found here.
          if (last) begin
            state       <= DONE;
            out_valid   <= 1'b1;
            min_presses <= hit ? presses_next : (found ? best : '0);
            solvable    <= hit || found;
`ifdef DAY10_SOLVER_PRESS_MASK_EN
            best_mask   <= hit ? gray[MAX_NUM_BUTTONS-1:0] : best_gray;
`endif
          end else begin
            k <= k + KW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_day10_min_presses_solver.sv
// Self-checking bench for day10_min_presses_solver against a brute-force subset model.
module tb_day10_min_presses_solver;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   num_lights;
  logic [3:0]   num_buttons;
  logic [129:0] buttons;
  logic [9:0]   target;
  logic         out_valid;
  logic         out_ready;
  logic [3:0]   min_presses;
  logic         solvable;
`ifdef DAY10_SOLVER_PRESS_MASK_EN
  logic [12:0]  best_mask;
`endif

  int vectors;
  int miscompares;

  day10_min_presses_solver dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .in_valid                  (in_valid),
    .in_ready                  (in_ready),
    .num_lights                (num_lights),
    .num_buttons               (num_buttons),
    .buttons                   (buttons),
    .target_lights_arrangement (target),
    .out_valid                 (out_valid),
    .out_ready                 (out_ready),
    .min_presses               (min_presses),
    .solvable                  (solvable)
`ifdef DAY10_SOLVER_PRESS_MASK_EN
    ,
    .best_mask                 (best_mask)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Try every subset outright and keep the smallest popcount that hits the target.
  function automatic void refModel(input int lights, input int nbtn, input logic [129:0] btns,
                                   input logic [9:0] tgt, output int minp, output bit solv);
    int         l_eff;
    int         n_eff;
    int         best;
    logic [9:0] lm;
    logic [9:0] t;
    logic [9:0] x;
    l_eff = (lights > 10) ? 10 : lights;
    n_eff = (nbtn > 13) ? 13 : nbtn;
    lm = '0;
    for (int j = 0; j < l_eff; j++) lm[j] = 1'b1;
    t = tgt & lm;
    best = -1;
    for (int s = 0; s < (1 << n_eff); s++) begin
      x = '0;
      for (int i = 0; i < n_eff; i++)
        if (s[i]) x = x ^ (btns[i*10 +: 10] & lm);
      if (x == t && (best < 0 || $countones(s) < best)) best = $countones(s);
    end
    solv = (best >= 0);
    minp = solv ? best : 0;
  endfunction

  function automatic logic [129:0] randomButtons();
    logic [129:0] b;
    for (int i = 0; i < 13; i++) b[i*10 +: 10] = 10'($urandom);
    return b;
  endfunction

  task automatic applyStimulus(input string tag, input int lights, input int nbtn,
                               input logic [129:0] btns, input logic [9:0] tgt, input int hold);
    int exp_min;
    bit exp_solv;
    int n_eff;
    int cyc;
    int budget;
    refModel(lights, nbtn, btns, tgt, exp_min, exp_solv);
    n_eff = (nbtn > 13) ? 13 : nbtn;
    budget = 0;
    while (!in_ready && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    checkOutput({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
    num_lights  = 4'(lights);
    num_buttons = 4'(nbtn);
    buttons     = btns;
    target      = tgt;
    in_valid    = 1'b1;
    @(posedge clk); #1;
    in_valid    = 1'b0;
    num_lights  = 4'($urandom);
    num_buttons = 4'($urandom);
    buttons     = randomButtons();
    target      = 10'($urandom);
    cyc = 1;
    while (!out_valid && cyc < 9000) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput({tag, " latency"}, 32'(cyc), 32'(1 << n_eff));
    checkOutput({tag, " min_presses"}, 32'(min_presses), 32'(exp_min));
    checkOutput({tag, " solvable"}, 32'(solvable), 32'(exp_solv));
    checkOutput({tag, " in_ready busy"}, 32'(in_ready), 32'd0);
`ifdef DAY10_SOLVER_PRESS_MASK_EN
    checkOutput({tag, " best_mask weight"}, 32'($countones(best_mask)), 32'(exp_min));
`endif
    if (hold > 0) begin
      in_valid    = 1'b1;
      num_buttons = 4'd1;
      target      = 10'h3ff;
      for (int c = 0; c < hold; c++) begin
        @(posedge clk); #1;
        checkOutput({tag, " held out_valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, " held min_presses"}, 32'(min_presses), 32'(exp_min));
        checkOutput({tag, " held solvable"}, 32'(solvable), 32'(exp_solv));
        checkOutput({tag, " held in_ready"}, 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({tag, " out_valid after release"}, 32'(out_valid), 32'd0);
    checkOutput({tag, " in_ready after release"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [129:0] b;
    int           lr;
    int           nr;
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    num_lights  = '0;
    num_buttons = '0;
    buttons     = '0;
    target      = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset min_presses", 32'(min_presses), 32'd0);
    checkOutput("reset solvable", 32'(solvable), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    b = '0;
    b[0*10 +: 10] = 10'b1000;
    b[1*10 +: 10] = 10'b1010;
    b[2*10 +: 10] = 10'b0100;
    b[3*10 +: 10] = 10'b1100;
    b[4*10 +: 10] = 10'b0101;
    b[5*10 +: 10] = 10'b0011;
    applyStimulus("six buttons", 4, 6, b, 10'b0110, 0);

    b = '0;
    b[0*10 +: 10] = 10'b11101;
    b[1*10 +: 10] = 10'b01100;
    b[2*10 +: 10] = 10'b10001;
    b[3*10 +: 10] = 10'b00111;
    b[4*10 +: 10] = 10'b11110;
    applyStimulus("five buttons", 5, 5, b, 10'b01000, 0);

    b = '0;
    b[0*10 +: 10] = 10'b10;
    applyStimulus("unsolvable", 2, 1, b, 10'b01, 0);

    applyStimulus("zero target", 6, 3, randomButtons(), 10'b0, 0);
    applyStimulus("backpressure", 6, 4, randomButtons(), 10'($urandom), 10);
    applyStimulus("high bits masked", 4, 5, randomButtons(), 10'($urandom) | 10'h3f0, 0);
    applyStimulus("clamp lights and buttons", 15, 15, randomButtons(), 10'($urandom), 0);

    for (int r = 0; r < 6; r++) begin
      lr = int'($urandom_range(0, 15));
      nr = int'($urandom_range(0, 9));
      applyStimulus($sformatf("random %0d", r), lr, nr, randomButtons(), 10'($urandom), 0);
    end

    // Abort a long search partway and make sure the machine comes back clean.
    num_lights  = 4'd10;
    num_buttons = 4'd10;
    buttons     = randomButtons();
    target      = 10'($urandom) | 10'h001;
    in_valid    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    b = '0;
    b[0*10 +: 10] = 10'b1000;
    b[1*10 +: 10] = 10'b1010;
    b[2*10 +: 10] = 10'b0100;
    b[3*10 +: 10] = 10'b1100;
    b[4*10 +: 10] = 10'b0101;
    b[5*10 +: 10] = 10'b0011;
    applyStimulus("after abort", 4, 6, b, 10'b0110, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
